// File: rtl/de2_io_pkg.sv
// Shared DE2 board I/O constants: pad counts, clock rate, debounce default and
// the field layout of the 32-bit word presented to the CPU input register.
package de2_io_pkg;

  localparam int DE2_SW_WIDTH        = 18;
  localparam int DE2_KEY_WIDTH       = 4;
  localparam int DE2_CLK_HZ          = 50_000_000;
  localparam int DE2_DEBOUNCE_CYCLES = DE2_CLK_HZ / 50;

  localparam int CPU_WORD_W  = 32;
  localparam int SW_LSB      = 0;
  localparam int KEYLVL_LSB  = 18;
  localparam int KEYFLAG_LSB = 22;

endpackage

// File: rtl/debounce_cell.sv
// One input bit: a synchroniser chain followed by a stability counter that only
// accepts a new level after it has persisted for DEBOUNCE_CYCLES cycles.
module debounce_cell #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter int   CNT_W           = $clog2(DEBOUNCE_CYCLES),
  parameter logic RESET_VAL       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];
  assign dout   = stable_q;

  // Any disagreement that does not last the full window restarts the count.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], din};
    cnt_d    = '0;
    stable_d = stable_q;
    if (synced != stable_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = synced;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q   <= {SYNC_STAGES{RESET_VAL}};
      cnt_q    <= '0;
      stable_q <= RESET_VAL;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

endmodule

// File: rtl/input_debouncer.sv
// DE2 switch/button front end: debounced levels, press pulses, sticky press
// flags cleared by the CPU, and the packed CPU input word.
module input_debouncer
  import de2_io_pkg::*;
#(
  parameter int SW_WIDTH        = DE2_SW_WIDTH,
  parameter int KEY_WIDTH       = DE2_KEY_WIDTH,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DE2_DEBOUNCE_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SW_WIDTH-1:0]   sw_raw,
  input  logic [KEY_WIDTH-1:0]  key_raw,
  input  logic [KEY_WIDTH-1:0]  ack,
  output logic [SW_WIDTH-1:0]   sw_stable,
  output logic [KEY_WIDTH-1:0]  key_level,
  output logic [KEY_WIDTH-1:0]  key_press,
  output logic [KEY_WIDTH-1:0]  key_flag,
  output logic [CPU_WORD_W-1:0] cpu_word
);

  localparam int NBITS = SW_WIDTH + KEY_WIDTH;

  logic [NBITS-1:0]     raw_all, stable_all;
  logic [KEY_WIDTH-1:0] key_lvl_prev_q, key_lvl_prev_d;
  logic [KEY_WIDTH-1:0] key_press_q, key_press_d;
  logic [KEY_WIDTH-1:0] key_flag_q, key_flag_d;

  assign raw_all = {key_raw, sw_raw};

  // KEY cells debounce the raw active-low pad, so they idle (and reset) at 1.
  for (genvar i = 0; i < NBITS; i++) begin : g_cell
    debounce_cell #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W),
      .RESET_VAL      ((i >= SW_WIDTH) ? 1'b1 : 1'b0)
    ) u_cell (
      .clk (clk),
      .rst (rst),
      .din (raw_all[i]),
      .dout(stable_all[i])
    );
  end

  assign sw_stable = stable_all[SW_WIDTH-1:0];
  assign key_level = ~stable_all[NBITS-1:SW_WIDTH];
  assign key_press = key_press_q;
  assign key_flag  = key_flag_q;

  // A pending press wins over a same-cycle ack so no event is lost.
  always_comb begin
    key_lvl_prev_d = key_level;
    key_press_d    = key_level & ~key_lvl_prev_q;
    key_flag_d     = key_press_q | (key_flag_q & ~ack);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_lvl_prev_q <= '0;
      key_press_q    <= '0;
      key_flag_q     <= '0;
    end else begin
      key_lvl_prev_q <= key_lvl_prev_d;
      key_press_q    <= key_press_d;
      key_flag_q     <= key_flag_d;
    end
  end

  always_comb begin
    cpu_word                              = '0;
    cpu_word[SW_LSB      +: SW_WIDTH]     = sw_stable;
    cpu_word[KEYLVL_LSB  +: KEY_WIDTH]    = key_level;
    cpu_word[KEYFLAG_LSB +: KEY_WIDTH]    = key_flag_q;
  end

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: directed scenarios followed by random pad activity,
// every cycle compared against a window-based reference model.
module tb_input_debouncer;

  localparam int S = 2;
  localparam int D = 4;
  localparam int N = 22;
  localparam logic [N-1:0] RST_RAW = {4'hF, 18'h0};

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] sw_raw;
  logic [3:0]  key_raw;
  logic [3:0]  ack;
  logic [17:0] sw_stable;
  logic [3:0]  key_level, key_press, key_flag;
  logic [31:0] cpu_word;

  int checks   = 0;
  int failures = 0;

  input_debouncer #(
    .SW_WIDTH(18), .KEY_WIDTH(4), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk), .rst(rst), .sw_raw(sw_raw), .key_raw(key_raw), .ack(ack),
    .sw_stable(sw_stable), .key_level(key_level), .key_press(key_press),
    .key_flag(key_flag), .cpu_word(cpu_word)
  );

  always #5 clk = ~clk;

  // Reference: a pad bit is synchronised S cycles late, and the stable level
  // flips once the last D synchronised samples all disagree with it.
  logic [N-1:0] hist[$];
  logic [N-1:0] win[$];
  logic [N-1:0] m_stable;
  logic [3:0]   m_lvl, m_lvl_prev, m_press, m_flag;

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < S; k++) hist.push_back(RST_RAW);
    win.delete();
    m_stable   = RST_RAW;
    m_lvl      = '0;
    m_lvl_prev = '0;
    m_press    = '0;
    m_flag     = '0;
  endtask

  task automatic model_edge(input logic [N-1:0] raw, input logic [3:0] ackv);
    logic [N-1:0] synced, new_stable;
    logic [3:0]   new_press, new_flag;
    logic         all_diff;
    synced = hist.pop_front();
    hist.push_back(raw);
    win.push_back(synced);
    if (win.size() > D) void'(win.pop_front());
    new_stable = m_stable;
    if (win.size() == D) begin
      for (int b = 0; b < N; b++) begin
        all_diff = 1'b1;
        foreach (win[k]) if (win[k][b] == m_stable[b]) all_diff = 1'b0;
        if (all_diff) new_stable[b] = ~m_stable[b];
      end
    end
    new_press  = m_lvl & ~m_lvl_prev;
    new_flag   = m_press | (m_flag & ~ackv);
    m_lvl_prev = m_lvl;
    m_stable   = new_stable;
    m_lvl      = ~new_stable[21:18];
    m_press    = new_press;
    m_flag     = new_flag;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("m_sw_stable", 32'(sw_stable), 32'(m_stable[17:0]));
    check("m_key_level", 32'(key_level), 32'(m_lvl));
    check("m_key_press", 32'(key_press), 32'(m_press));
    check("m_key_flag",  32'(key_flag),  32'(m_flag));
    check("m_cpu_word",  cpu_word, {6'b0, m_flag, m_lvl, m_stable[17:0]});
  endtask

  task automatic step(input int n);
    logic [N-1:0] raw;
    logic [3:0]   a;
    for (int k = 0; k < n; k++) begin
      raw = {key_raw, sw_raw};
      a   = ack;
      @(posedge clk);
      model_edge(raw, a);
      #1;
      check_model();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sw"},   32'(sw_stable), 32'h0);
    check({tag, "_lvl"},  32'(key_level), 32'h0);
    check({tag, "_prs"},  32'(key_press), 32'h0);
    check({tag, "_flag"}, 32'(key_flag),  32'h0);
    check({tag, "_word"}, cpu_word,       32'h0);
  endtask

  initial begin
    int idx;
    rst = 1'b0; sw_raw = '0; key_raw = 4'hF; ack = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    model_reset();
    rst = 1'b1;

    // Switch word appears after sync + debounce.
    sw_raw = 18'h2A5A5;
    step(5); check("t1_early", 32'(sw_stable), 32'h0);
    step(1); check("t1_sw", 32'(sw_stable), 32'h2A5A5);
    check("t1_word", cpu_word, 32'h0002A5A5);

    // Bouncing bit 0 never glitches the stable output.
    sw_raw = 18'h2A5A4;
    step(6); check("t2_base", 32'(sw_stable), 32'h2A5A4);
    for (int t = 0; t < 4; t++) begin
      sw_raw[0] = t[0];
      for (int c = 0; c < 2; c++) begin
        step(1); check("t2_bounce", 32'(sw_stable[0]), 32'h0);
      end
    end
    step(3); check("t2_hold_early", 32'(sw_stable[0]), 32'h0);
    step(1); check("t2_hold", 32'(sw_stable[0]), 32'h1);

    // Press key 1.
    key_raw = 4'b1101;
    step(6); check("t3_lvl", 32'(key_level), 32'h2);
    check("t3_nopulse", 32'(key_press), 32'h0);
    step(1); check("t3_press", 32'(key_press), 32'h2);
    check("t3_flag_pre", 32'(key_flag), 32'h0);
    step(1); check("t3_flag", 32'(key_flag), 32'h2);
    check("t3_pulse_end", 32'(key_press), 32'h0);
    check("t3_w23", 32'(cpu_word[23]), 32'h1);
    check("t3_w19", 32'(cpu_word[19]), 32'h1);

    // Key 2: ack in the press cycle loses to the set; later ack clears it.
    key_raw = 4'b1001;
    step(7); check("t4_press", 32'(key_press), 32'h4);
    ack = 4'b0100;
    step(1); check("t4_setwins", 32'(key_flag), 32'h6);
    ack = 4'b0000;
    step(2);
    ack = 4'b0100;
    step(1); check("t4_clear", 32'(key_flag), 32'h2);
    ack = 4'b0000;

    // Release key 1: level drops, no pulse, flag untouched.
    key_raw = 4'b1011;
    step(5); check("t5_early", 32'(key_level), 32'h6);
    step(1); check("t5_lvl", 32'(key_level), 32'h4);
    step(2); check("t5_flag", 32'(key_flag), 32'h2);

    // Reset mid-debounce clears everything and restarts the full delay.
    key_raw = 4'b1010;
    step(4);
    #2 rst = 1'b0;
    #1 check_all_zero("t6_rst");
    model_reset();
    #2 rst = 1'b1;
    step(5); check("t6_early", 32'(key_level), 32'h0);
    step(1); check("t6_lvl", 32'(key_level), 32'h5);
    check("t6_sw", 32'(sw_stable), 32'h2A5A5);

    // Random pad activity and acks against the model.
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 5) == 0) begin
        idx = $urandom_range(0, 17);
        sw_raw[idx] = ~sw_raw[idx];
      end
      if ($urandom_range(0, 5) == 0) begin
        idx = $urandom_range(0, 3);
        key_raw[idx] = ~key_raw[idx];
      end
      ack = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      step(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
